// File: rtl/mode4_adder_ctrl_pkg.sv
// Shared types and defaults for the mode-4 adder-tree sequencer.
// FSM state encoding plus default pair-buffer geometry.
package mode4_adder_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_RD_LAT     = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mode4_adder_ctrl_valid_pipe.sv
// Delays pair-buffer read enables into the stage-1/stage-0 run strobes (RD_LAT and RD_LAT+1 cycles).
// No backpressure: bubbles in i_vld travel through as gaps in both strobes.
module mode4_valid_pipe
    import mode4_adder_ctrl_pkg::*;
#(
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vld,
    output logic o_stage1_run,
    output logic o_stage0_run,
    output logic o_empty_next
);

    localparam int DEPTH = RD_LAT + 1;

    logic [DEPTH-1:0] r_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= {r_pipe[DEPTH-2:0], i_vld};
        end
    end

    assign o_stage1_run = r_pipe[RD_LAT-1];
    assign o_stage0_run = r_pipe[RD_LAT];
    // Only the stage-0 slot may be occupied: after this cycle the pipe is empty.
    assign o_empty_next = ~i_vld & ~(|r_pipe[DEPTH-2:0]);

endmodule

// File: rtl/mode4_adder_ctrl.sv
// Sequences one mode-4 adder tree: clear, stream N pairs, drain, pulse done (done at N+3+RD_LAT).
// pause holds issue; pairs already in flight still complete.
module mode4_adder_ctrl
    import mode4_adder_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RD_LAT     = DEF_RD_LAT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_pairs,
    input  logic                  pause,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  tree_clr,
    output logic                  mode4_stage1_run,
    output logic                  mode4_stage0_run,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_left;
    logic                  r_busy;
    logic                  r_clr;
    logic                  r_done;

    logic                  w_rd_en;
    logic                  w_empty_next;

    assign w_rd_en = (r_state == ST_ISSUE) && !pause;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_left  <= '0;
            r_busy  <= 1'b0;
            r_clr   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr  <= base_addr;
                        r_left  <= num_pairs;
                        r_busy  <= 1'b1;
                        r_clr   <= 1'b1;
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_clr <= 1'b0;
                    if (r_left == '0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_rd_en) begin
                        r_addr <= r_addr + 1'b1;
                        r_left <= r_left - CNT_ONE;
                        if (r_left == CNT_ONE) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_empty_next) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_clr   <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    mode4_valid_pipe #(
        .RD_LAT (RD_LAT)
    ) u_valid_pipe (
        .clk          (clk),
        .rst_n        (reset),
        .i_vld        (w_rd_en),
        .o_stage1_run (mode4_stage1_run),
        .o_stage0_run (mode4_stage0_run),
        .o_empty_next (w_empty_next)
    );

    assign rd_en    = w_rd_en;
    assign rd_addr  = w_rd_en ? r_addr : '0;
    assign tree_clr = r_clr;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: doc/mode4_adder_ctrl.md
Name: mode4_adder_ctrl

Overview:
Sequencer for the mode-4 two-input FP adder tree, which is a one-adder stage 1 followed by a stage-0 accumulator.
- On start, it clears the tree accumulator and streams N operand pairs from a pair buffer (address/read-enable).
- It asserts the stage-1 and stage-0 run strobes aligned with buffer read latency, then signals completion once the accumulated sum is stable.
- It sits between the softmax top-level FSM and one mode4 adder tree instance.

Parameters:
ADDR_WIDTH, 8, pair-buffer address width; also sets the max pair count of 2^ADDR_WIDTH.
RD_LAT, 1, pair-buffer read latency in cycles (rd_en to inp0/inp1 valid); legal range 1..4.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
start  input  1  one-cycle launch pulse; sampled in IDLE only.
base_addr  input  ADDR_WIDTH  first pair address; captured on accepted start.
num_pairs  input  ADDR_WIDTH+1  number of pairs to accumulate (0..2^ADDR_WIDTH); captured on accepted start.
pause  input  1  when 1, no new read is issued; in-flight pairs still complete.
rd_en  output  1  pair-buffer read enable.
rd_addr  output  ADDR_WIDTH  pair-buffer read address.
tree_clr  output  1  drives the adder tree's synchronous active-high reset; zeroes its accumulator.
mode4_stage1_run  output  1  stage-1 register enable.
mode4_stage0_run  output  1  stage-0 accumulator enable.
busy  output  1  high from accepted start until done.
done  output  1  one-cycle pulse; tree outp holds the final sum in this cycle.

Behaviour:
- Reset (reset=0, any time, including mid-run): state goes to IDLE; all outputs, counters and the valid pipe are 0. Effect is immediate (async). The tree accumulator is not cleared by this block's reset; the next run clears it via CLEAR.
- FSM states: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE: outputs 0. On start=1, capture base_addr and num_pairs, go to CLEAR.
- CLEAR: one cycle, tree_clr=1, busy=1.
  - If num_pairs==0, go to DONE; the final result is 0.
  - Otherwise go to ISSUE.
- ISSUE: busy=1.
  - Each cycle with pause=0: rd_en=1, rd_addr=current address; then address+1 (mod 2^ADDR_WIDTH, wraps) and remaining count -1.
  - With pause=1: rd_en=0; address and count hold.
  - When the last read issues, go to DRAIN.
- Valid pipe: a shift register of depth RD_LAT+1 fed by rd_en.
  - mode4_stage1_run = rd_en delayed by RD_LAT.
  - mode4_stage0_run = rd_en delayed by RD_LAT+1.
  - Bubbles from pause propagate as gaps in both strobes; the accumulator simply holds.
- DRAIN: busy=1, rd_en=0. Stay until the valid pipe is all zero and the last stage0_run has been issued, then go to DONE.
- DONE: one cycle, done=1, busy=1, then IDLE. The last stage0 accumulation edge precedes the DONE cycle, so outp is final while done=1.
- Latency (no pause), start accepted at cycle 0:
  - CLEAR at cycle 1; reads at cycles 2..N+1.
  - Last stage0_run at cycle N+2+RD_LAT; done at cycle N+3+RD_LAT.
- start while busy: ignored, with no effect on captured values.
- start in the same cycle as DONE: ignored. A new run needs start in IDLE.
- pause is ignored outside ISSUE.
- tree_clr is never high in the same cycle as either run strobe. The pipe is empty in CLEAR, so this holds by construction; assert it in verification.
- num_pairs=2^ADDR_WIDTH: reads every address exactly once, starting at base_addr with wrap.

Decomposition:
- Shared defines: state encoding constants (IDLE=0, CLEAR=1, ISSUE=2, DRAIN=3, DONE=4, 3-bit), and ADDR_WIDTH/RD_LAT defaults alongside the existing DATAWIDTH defines.
- One natural sub-module: mode4_valid_pipe, a parameterised-depth shift register with async active-low reset that produces the two run strobes and an empty flag.

Test Plan:
- RD_LAT=1, base=0x10, N=4, no pause; buffer pairs (1.0,2.0),(3.0,4.0),(5.0,6.0),(7.0,8.0).
  - rd_addr 0x10..0x13 on cycles 2..5; stage1_run cycles 3..6; stage0_run cycles 4..7.
  - done at cycle 8, tree outp=36.0, busy low at cycle 9.
- N=0 -> CLEAR then DONE: done at cycle 2, rd_en never high, outp=0.0 even if the previous run left 36.0.
- N=3, pause high during the second read cycle -> rd_en pattern 1,0,1,1; strobes show the same single-cycle gap; done one cycle later than the unpaused run; sum correct.
- base=0xFE, N=4, ADDR_WIDTH=8 -> rd_addr sequence 0xFE,0xFF,0x00,0x01.
- Second start pulse mid-ISSUE with different base/N -> ignored: addresses, count and result unchanged. Reset driven low mid-ISSUE -> all outputs 0 immediately, then IDLE. A following run with N=2 of (1.0,1.0) pairs yields 4.0.
- RD_LAT=3, N=2 -> stage1_run 3 cycles after each rd_en, stage0_run 4 cycles after; done at cycle 2+3+3=8.
